// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bip_pkg
// Purpose  : Shared definitions for the BIP accumulator machine: default
//            widths, opcode values, sequencer state encoding and the
//            datapath select/ALU encodings.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package bip_pkg;

  localparam int C_NBITS_PC  = 11;
  localparam int C_NBITS_I   = 16;
  localparam int C_NBITS_OP  = 5;
  localparam int C_NBITS_O   = 11;
  localparam int C_NBITS_CNT = 16;

  localparam logic [4:0] C_OPC_HLT  = 5'b00000;
  localparam logic [4:0] C_OPC_STO  = 5'b00001;
  localparam logic [4:0] C_OPC_LD   = 5'b00010;
  localparam logic [4:0] C_OPC_LDI  = 5'b00011;
  localparam logic [4:0] C_OPC_ADD  = 5'b00100;
  localparam logic [4:0] C_OPC_ADDI = 5'b00101;
  localparam logic [4:0] C_OPC_SUB  = 5'b00110;
  localparam logic [4:0] C_OPC_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] C_SELA_RAM = 2'd0;
  localparam logic [1:0] C_SELA_IMM = 2'd1;
  localparam logic [1:0] C_SELA_ALU = 2'd2;
  localparam logic       C_SELB_RAM = 1'b0;
  localparam logic       C_SELB_IMM = 1'b1;
  localparam logic       C_ALU_ADD  = 1'b0;
  localparam logic       C_ALU_SUB  = 1'b1;

  // Opcodes whose operand is a data-RAM address that must be read ahead of EXEC.
  function automatic logic reads_ram(input logic [4:0] opc);
    return (opc == C_OPC_LD) || (opc == C_OPC_ADD) || (opc == C_OPC_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bip_if.sv
`default_nettype none
// ============================================================================
// Module   : bip_if
// Purpose  : Bundle of program-ROM, data-RAM and datapath control signals
//            between the sequencer (master) and its environment (slave).
// Signals  : i_start, i_Instruction (to sequencer); o_PC, o_Operand,
//            o_SelA, o_SelB, o_WrAcc, o_Op, o_RdRam, o_WrRam, o_busy,
//            o_halted, o_illegal, o_icount (from sequencer)
// Revision : 1.0  initial release
// ============================================================================
interface bip_if #(
  parameter int NBITS_PC  = 11,
  parameter int NBITS_I   = 16,
  parameter int NBITS_O   = 11,
  parameter int NBITS_CNT = 16
);
  logic                 i_start;
  logic [NBITS_I-1:0]   i_Instruction;
  logic [NBITS_PC-1:0]  o_PC;
  logic [NBITS_O-1:0]   o_Operand;
  logic [1:0]           o_SelA;
  logic                 o_SelB;
  logic                 o_WrAcc;
  logic                 o_Op;
  logic                 o_RdRam;
  logic                 o_WrRam;
  logic                 o_busy;
  logic                 o_halted;
  logic                 o_illegal;
  logic [NBITS_CNT-1:0] o_icount;

  modport master (
    input  i_start, i_Instruction,
    output o_PC, o_Operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_RdRam, o_WrRam,
           o_busy, o_halted, o_illegal, o_icount
  );

  modport slave (
    output i_start, i_Instruction,
    input  o_PC, o_Operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_RdRam, o_WrRam,
           o_busy, o_halted, o_illegal, o_icount
  );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Purpose  : Program counter with increment enable; wraps silently.
// Ports    : i_clock, i_reset (async, active-high), i_inc, o_pc
// Revision : 1.0  initial release
// ============================================================================
module program_counter #(
  parameter int NBITS_PC = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_inc,
  output logic [NBITS_PC-1:0] o_pc
);
  logic [NBITS_PC-1:0] r_pc;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_pc <= '0;
    else if (i_inc)
      r_pc <= r_pc + NBITS_PC'(1);
  end

  assign o_pc = r_pc;
endmodule
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module   : bip_control
// Purpose  : Multi-cycle FETCH/DECODE/EXEC sequencer for the accumulator
//            datapath. Fetches from a synchronous program ROM, pre-reads data
//            RAM in DECODE, issues datapath controls for one EXEC cycle.
// Ports    : i_clock, i_reset (async, active-high), bus (bip_if.master)
// Revision : 1.0  initial release
// ============================================================================
module bip_control
  import bip_pkg::*;
#(
  parameter int NBITS_PC  = C_NBITS_PC,
  parameter int NBITS_I   = C_NBITS_I,
  parameter int NBITS_OP  = C_NBITS_OP,
  parameter int NBITS_O   = C_NBITS_O,
  parameter int NBITS_CNT = C_NBITS_CNT
) (
  input logic  i_clock,
  input logic  i_reset,
  bip_if.master bus
);
  state_t               r_state;
  state_t               w_state_next;
  logic [NBITS_I-1:0]   r_ir;
  logic [NBITS_CNT-1:0] r_icount;
  logic                 r_illegal;

  logic [NBITS_OP-1:0]  w_ir_opc;
  logic [NBITS_OP-1:0]  w_fetch_opc;
  logic [1:0]           w_sel_a;
  logic                 w_sel_b;
  logic                 w_op;
  logic                 w_wr_acc;
  logic                 w_wr_ram;
  logic                 w_rd_ram;
  logic                 w_illegal_exec;
  logic                 w_retire;
  logic                 w_pc_inc;

  assign w_ir_opc    = r_ir[NBITS_I-1 -: NBITS_OP];
  assign w_fetch_opc = bus.i_Instruction[NBITS_I-1 -: NBITS_OP];

  // HLT retires straight out of DECODE; every other instruction retires in EXEC.
  assign w_pc_inc = (r_state == ST_EXEC);
  assign w_retire = w_pc_inc || ((r_state == ST_DECODE) && (w_fetch_opc == C_OPC_HLT));

  program_counter #(.NBITS_PC(NBITS_PC)) u_pc (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_pc_inc),
    .o_pc    (bus.o_PC)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_icount  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE)
        r_ir <= bus.i_Instruction;
      if (w_retire && (r_icount != '1))
        r_icount <= r_icount + NBITS_CNT'(1);
      if (w_illegal_exec)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sel_a        = C_SELA_RAM;
    w_sel_b        = C_SELB_RAM;
    w_op           = C_ALU_ADD;
    w_wr_acc       = 1'b0;
    w_wr_ram       = 1'b0;
    w_rd_ram       = 1'b0;
    w_illegal_exec = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (bus.i_start) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        // RAM address comes from the ROM word directly so data is ready in EXEC.
        w_rd_ram     = reads_ram(w_fetch_opc);
        w_state_next = (w_fetch_opc == C_OPC_HLT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_FETCH;
        case (w_ir_opc)
          C_OPC_HLT:  ;
          C_OPC_STO:  w_wr_ram = 1'b1;
          C_OPC_LD:   begin w_sel_a = C_SELA_RAM; w_wr_acc = 1'b1; end
          C_OPC_LDI:  begin w_sel_a = C_SELA_IMM; w_wr_acc = 1'b1; end
          C_OPC_ADD:  begin w_sel_a = C_SELA_ALU; w_sel_b = C_SELB_RAM; w_op = C_ALU_ADD; w_wr_acc = 1'b1; end
          C_OPC_ADDI: begin w_sel_a = C_SELA_ALU; w_sel_b = C_SELB_IMM; w_op = C_ALU_ADD; w_wr_acc = 1'b1; end
          C_OPC_SUB:  begin w_sel_a = C_SELA_ALU; w_sel_b = C_SELB_RAM; w_op = C_ALU_SUB; w_wr_acc = 1'b1; end
          C_OPC_SUBI: begin w_sel_a = C_SELA_ALU; w_sel_b = C_SELB_IMM; w_op = C_ALU_SUB; w_wr_acc = 1'b1; end
          default:    w_illegal_exec = 1'b1;  // undefined opcode executes as NOP
        endcase
      end
      ST_HALT:   w_state_next = ST_HALT;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign bus.o_Operand = r_ir[NBITS_O-1:0];
  assign bus.o_SelA    = w_sel_a;
  assign bus.o_SelB    = w_sel_b;
  assign bus.o_Op      = w_op;
  assign bus.o_WrAcc   = w_wr_acc;
  assign bus.o_WrRam   = w_wr_ram;
  assign bus.o_RdRam   = w_rd_ram;
  assign bus.o_busy    = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
  assign bus.o_halted  = (r_state == ST_HALT);
  assign bus.o_illegal = r_illegal;
  assign bus.o_icount  = r_icount;
endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_control
// Purpose  : Self-checking bench for bip_control: instruction-level reference
//            interpreter feeds a scoreboard queue; a monitor compares every
//            FETCH/DECODE/EXEC/HALT cycle. Includes a small-width instance for
//            PC wrap and retired-count saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_bip_control;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  bip_if #(.NBITS_PC(11), .NBITS_I(16), .NBITS_O(11), .NBITS_CNT(16)) bus ();
  bip_if #(.NBITS_PC(4),  .NBITS_I(16), .NBITS_O(11), .NBITS_CNT(4))  bus2 ();

  bip_control #(.NBITS_PC(11), .NBITS_I(16), .NBITS_OP(5), .NBITS_O(11), .NBITS_CNT(16)) dut (
    .i_clock (clk), .i_reset (rst), .bus (bus));
  bip_control #(.NBITS_PC(4), .NBITS_I(16), .NBITS_OP(5), .NBITS_O(11), .NBITS_CNT(4)) dut2 (
    .i_clock (clk), .i_reset (rst2), .bus (bus2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sext(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  // ---------------- environment: sync ROM, data RAM, accumulator ----------
  logic [15:0] rom      [2048];
  logic [15:0] init_ram [2048];
  logic [15:0] dram     [2048];
  logic [15:0] acc;
  logic [15:0] ram_q;
  logic        env_load = 1'b0;

  always @(posedge clk) bus.i_Instruction <= rom[bus.o_PC];

  always @(posedge clk) begin
    if (env_load) begin
      for (int i = 0; i < 2048; i++) dram[i] <= init_ram[i];
      acc   <= '0;
      ram_q <= '0;
    end else begin
      if (bus.o_RdRam) ram_q <= dram[bus.i_Instruction[10:0]];
      if (bus.o_WrRam) dram[bus.o_Operand] <= acc;
      if (bus.o_WrAcc) begin
        case (bus.o_SelA)
          2'd0:    acc <= ram_q;
          2'd1:    acc <= sext(bus.o_Operand);
          default: acc <= bus.o_Op ? acc - (bus.o_SelB ? sext(bus.o_Operand) : ram_q)
                                   : acc + (bus.o_SelB ? sext(bus.o_Operand) : ram_q);
        endcase
      end
    end
  end

  // ---------------- reference model ---------------------------------------
  typedef struct {
    logic [10:0] pc;
    bit          hlt;
    bit          rd;
    logic [1:0]  sela;
    bit          selb;
    bit          op;
    bit          wracc;
    bit          wrram;
    logic [10:0] operand;
    logic [15:0] acc;
    int          icount;
    bit          illegal;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_ram [2048];
  logic [15:0] m_acc;
  logic [10:0] m_pc;
  int          m_icount;
  bit          m_illegal;

  // Interprets the program one instruction at a time, recording the control
  // pattern each instruction must produce and the architectural state after it.
  task automatic run_model(input int max_steps);
    exp_t        e;
    logic [15:0] ins;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) model_ram[i] = init_ram[i];
    m_acc = '0; m_pc = '0; m_icount = 0; m_illegal = 0;
    for (int s = 0; s < max_steps; s++) begin
      ins = rom[m_pc];
      a   = ins[10:0];
      e   = '{pc: m_pc, hlt: 0, rd: 0, sela: 2'd0, selb: 0, op: 0, wracc: 0, wrram: 0,
              operand: a, acc: 16'h0, icount: 0, illegal: 0};
      case (ins[15:11])
        5'd0: e.hlt = 1;
        5'd1: begin e.wrram = 1; model_ram[a] = m_acc; end
        5'd2: begin e.rd = 1; e.wracc = 1; m_acc = model_ram[a]; end
        5'd3: begin e.sela = 1; e.wracc = 1; m_acc = sext(a); end
        5'd4: begin e.rd = 1; e.sela = 2; e.wracc = 1; m_acc = m_acc + model_ram[a]; end
        5'd5: begin e.sela = 2; e.selb = 1; e.wracc = 1; m_acc = m_acc + sext(a); end
        5'd6: begin e.rd = 1; e.sela = 2; e.op = 1; e.wracc = 1; m_acc = m_acc - model_ram[a]; end
        5'd7: begin e.sela = 2; e.selb = 1; e.op = 1; e.wracc = 1; m_acc = m_acc - sext(a); end
        default: m_illegal = 1;
      endcase
      m_icount = m_icount + 1;
      e.acc = m_acc; e.icount = m_icount; e.illegal = m_illegal;
      q.push_back(e);
      if (e.hlt) break;
      m_pc = m_pc + 11'd1;
    end
  endtask

  // ---------------- monitor ------------------------------------------------
  bit   mon_en = 0;
  int   phase = 0;
  bit   acc_pend = 0;
  exp_t last;
  exp_t cur;
  int   rd_cnt = 0;

  always @(negedge clk) begin
    if (rst) rd_cnt = 0;
    else if (bus.o_RdRam) rd_cnt++;
    if (!mon_en || rst) begin
      phase = 0; acc_pend = 0;
    end else begin
      if (acc_pend) begin
        chk("acc_after", acc, last.acc);
        chk("icount_after", bus.o_icount, last.icount);
        chk("illegal_after", bus.o_illegal, last.illegal);
        acc_pend = 0;
      end
      if (bus.o_busy) begin
        if (q.size() == 0) begin
          chk("unexpected_busy", bus.o_busy, 0);
        end else begin
          cur = q[0];
          case (phase)
            0: begin
              chk("fetch_pc", bus.o_PC, cur.pc);
              chk("fetch_ctl", {bus.o_RdRam, bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op}, 0);
            end
            1: begin
              chk("decode_rdram", bus.o_RdRam, cur.rd);
              chk("decode_ctl", {bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op}, 0);
            end
            default: begin
              if (cur.hlt) chk("hlt_not_halted", bus.o_busy, 0);
              chk("exec_ctl", {bus.o_RdRam, bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op},
                  {1'b0, cur.wrram, cur.wracc, cur.sela, cur.selb, cur.op});
              chk("exec_operand", bus.o_Operand, cur.operand);
              last = cur;
              void'(q.pop_front());
              acc_pend = 1;
            end
          endcase
          phase = (phase >= 2) ? 0 : phase + 1;
        end
      end else if (bus.o_halted && q.size() > 0 && q[0].hlt) begin
        cur = q[0];
        chk("halt_phase", phase, 2);
        chk("halt_pc", bus.o_PC, cur.pc);
        chk("halt_icount", bus.o_icount, cur.icount);
        chk("halt_ctl", {bus.o_RdRam, bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op}, 0);
        void'(q.pop_front());
        phase = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin rom[i] = 16'h0; init_ram[i] = 16'h0; end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
    return {opc, opd};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; bus.i_start = 0; env_load = 1;
    @(negedge clk);
    rst = 0; env_load = 0;
  endtask

  task automatic run_prog(input string tag);
    int c;
    do_reset();
    q.delete();
    run_model(200);
    mon_en = 1;
    bus.i_start = 1;
    c = 0;
    while (!bus.o_halted && c < 2000) begin @(negedge clk); c++; end
    chk({tag, "_halt_timeout"}, bus.o_halted, 1);
    repeat (2) @(negedge clk);
    mon_en = 0;
    bus.i_start = 0;
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_final_pc"}, bus.o_PC, m_pc);
    chk({tag, "_final_icount"}, bus.o_icount, m_icount);
    chk({tag, "_final_illegal"}, bus.o_illegal, m_illegal);
    chk({tag, "_final_acc"}, acc, m_acc);
    for (int i = 0; i < 16; i++) chk({tag, "_ram"}, dram[i], model_ram[i]);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int c;
    logic [4:0]  opc;
    logic [10:0] opd;
    bus.i_start = 0;
    bus2.i_start = 0;
    bus2.i_Instruction = ins(C_OPC_LDI, 11'd1);
    clear_mem();

    // Reset state
    do_reset();
    chk("rst_pc", bus.o_PC, 0);
    chk("rst_status", {bus.o_busy, bus.o_halted, bus.o_illegal}, 0);
    chk("rst_icount", bus.o_icount, 0);
    chk("rst_operand", bus.o_Operand, 0);
    chk("rst_ctl", {bus.o_RdRam, bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op}, 0);

    // LDI 5, ADDI 3, STO 7, HLT
    clear_mem();
    rom[0] = ins(C_OPC_LDI, 11'd5); rom[1] = ins(C_OPC_ADDI, 11'd3);
    rom[2] = ins(C_OPC_STO, 11'd7); rom[3] = ins(C_OPC_HLT, 11'd0);
    run_prog("t1");
    chk("t1_ram7", dram[7], 16'd8);
    chk("t1_icount", bus.o_icount, 4);
    chk("t1_pc", bus.o_PC, 3);

    // LD 2, ADD 3, SUB 2, HLT with RAM[2]=10, RAM[3]=4
    clear_mem();
    init_ram[2] = 16'd10; init_ram[3] = 16'd4;
    rom[0] = ins(C_OPC_LD, 11'd2); rom[1] = ins(C_OPC_ADD, 11'd3);
    rom[2] = ins(C_OPC_SUB, 11'd2); rom[3] = ins(C_OPC_HLT, 11'd0);
    run_prog("t2");
    chk("t2_acc", acc, 16'd4);
    chk("t2_rdram_pulses", rd_cnt, 3);

    // SUBI 1 from zero
    clear_mem();
    rom[0] = ins(C_OPC_LDI, 11'd0); rom[1] = ins(C_OPC_SUBI, 11'd1);
    rom[2] = ins(C_OPC_HLT, 11'd0);
    run_prog("t3");
    chk("t3_acc", acc, 16'hFFFF);

    // Undefined opcode then HLT
    clear_mem();
    rom[0] = ins(5'b11111, 11'h155); rom[1] = ins(C_OPC_HLT, 11'd0);
    run_prog("t4");
    chk("t4_illegal", bus.o_illegal, 1);
    chk("t4_pc", bus.o_PC, 1);
    chk("t4_acc", acc, 16'd0);

    // Randomised programs
    for (int p = 0; p < 8; p++) begin
      clear_mem();
      for (int i = 0; i < 16; i++) init_ram[i] = 16'($urandom);
      for (int i = 0; i < 24; i++) begin
        c = $urandom_range(0, 9);
        if (c == 8) opc = 5'($urandom_range(8, 31));
        else        opc = 5'($urandom_range(1, 7));
        if (opc == C_OPC_STO || opc == C_OPC_LD || opc == C_OPC_ADD || opc == C_OPC_SUB)
          opd = 11'($urandom_range(0, 15));
        else
          opd = 11'($urandom_range(0, 2047));
        rom[i] = ins(opc, opd);
      end
      rom[24] = ins(C_OPC_HLT, 11'd0);
      run_prog("rand");
    end

    // Reset asserted during EXEC of ADDI
    clear_mem();
    rom[0] = ins(C_OPC_LDI, 11'd5); rom[1] = ins(C_OPC_ADDI, 11'd3);
    rom[2] = ins(C_OPC_HLT, 11'd0);
    do_reset();
    bus.i_start = 1;
    c = 0;
    while (!(bus.o_WrAcc && bus.o_SelB) && c < 50) begin @(negedge clk); c++; end
    chk("t5_reach_addi_exec", {bus.o_WrAcc, bus.o_SelB}, 2'b11);
    rst = 1;
    #1;
    chk("t5_ctl_zero", {bus.o_RdRam, bus.o_WrRam, bus.o_WrAcc, bus.o_SelA, bus.o_SelB, bus.o_Op}, 0);
    chk("t5_status_zero", {bus.o_busy, bus.o_halted, bus.o_illegal}, 0);
    chk("t5_pc_zero", bus.o_PC, 0);
    chk("t5_icount_zero", bus.o_icount, 0);
    @(negedge clk);
    chk("t5_acc_unwritten", acc, 16'd5);
    rst = 0;
    @(negedge clk);
    chk("t5_restart_busy", bus.o_busy, 1);
    chk("t5_restart_pc", bus.o_PC, 0);
    bus.i_start = 0;

    // Narrow instance: PC wrap at 15 and retired-count saturation at 15
    @(negedge clk); rst2 = 1;
    @(negedge clk); rst2 = 0;
    bus2.i_start = 1;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      repeat (3) @(negedge clk);
      chk("t6_pc", bus2.o_PC, k % 16);
      chk("t6_icount", bus2.o_icount, (k > 15) ? 15 : k);
    end
    bus2.i_start = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
